// File: rtl/shot_traj_if.sv
// Shot trajectory bus: launch/aim/pacing inputs and shot position/status outputs.
interface shot_traj_if;
   logic       fire;
   logic       step_tick;
   logic       hit;
   logic [4:0] x_pos;
   logic [4:0] run;
   logic [4:0] rise;
   logic       dir;
   logic [4:0] shot_x;
   logic [4:0] shot_y;
   logic       shot_active;
   logic       shot_done;
   logic       shot_hit;

   // Upstream/environment side: drives aim and pacing, observes the shot.
   modport master (
      output fire, step_tick, hit, x_pos, run, rise, dir,
      input  shot_x, shot_y, shot_active, shot_done, shot_hit
   );

   // Trajectory engine side.
   modport slave (
      input  fire, step_tick, hit, x_pos, run, rise, dir,
      output shot_x, shot_y, shot_active, shot_done, shot_hit
   );
endinterface

// File: rtl/shot_traj.sv
// Projectile trajectory engine: latches the aim vector on fire, steps the shot
// one move per tick across a 32-column field, reflecting off the side walls,
// and ends the flight on a collision hit or when the next step passes Y_MAX.
module shot_traj #(
   parameter int unsigned Y_MAX = 15
) (
   input logic        clk,
   input logic        reset,
   shot_traj_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FLY  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [5:0] Y_LIMIT = 6'(Y_MAX);

   state_t     state;
   logic [4:0] run_l;
   logic [4:0] rise_l;
   logic       dir_l;
   logic [4:0] x_r;
   logic [4:0] y_r;
   logic       active_r;
   logic       done_r;
   logic       hit_r;

   logic [5:0] x6;
   logic [5:0] run6;
   logic [5:0] x_sum;
   logic [5:0] y_sum;
   logic [4:0] next_x;
   logic       next_dir;
   logic       y_over;

   assign x6     = {1'b0, x_r};
   assign run6   = {1'b0, run_l};
   assign x_sum  = x6 + run6;
   assign y_sum  = {1'b0, y_r} + {1'b0, rise_l};
   assign y_over = (y_sum > Y_LIMIT);

   // Next column and direction; a wall crossing folds the overshoot back into
   // the field and reverses travel, so the result stays within 0..31.
   always_comb begin
      next_x   = x_r;
      next_dir = dir_l;
      if (!dir_l) begin
         if (run6 > x6) begin
            next_x   = 5'(run6 - x6);
            next_dir = 1'b1;
         end else begin
            next_x = 5'(x6 - run6);
         end
      end else begin
         if (x_sum > 6'd31) begin
            next_x   = 5'(6'd62 - x_sum);
            next_dir = 1'b0;
         end else begin
            next_x = 5'(x_sum);
         end
      end
   end

   // Flight FSM with registered position and status outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         run_l    <= '0;
         rise_l   <= '0;
         dir_l    <= 1'b0;
         x_r      <= '0;
         y_r      <= '0;
         active_r <= 1'b0;
         done_r   <= 1'b0;
         hit_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.fire && (bus.rise != 5'd0)) begin
                  run_l    <= bus.run;
                  rise_l   <= bus.rise;
                  dir_l    <= bus.dir;
                  x_r      <= bus.x_pos;
                  y_r      <= '0;
                  active_r <= 1'b1;
                  hit_r    <= 1'b0;
                  state    <= FLY;
               end
            end
            FLY: begin
               if (bus.hit) begin
                  active_r <= 1'b0;
                  done_r   <= 1'b1;
                  hit_r    <= 1'b1;
                  state    <= DONE;
               end else if (bus.step_tick) begin
                  if (y_over) begin
                     active_r <= 1'b0;
                     done_r   <= 1'b1;
                     hit_r    <= 1'b0;
                     state    <= DONE;
                  end else begin
                     y_r   <= 5'(y_sum);
                     x_r   <= next_x;
                     dir_l <= next_dir;
                  end
               end
            end
            DONE: begin
               done_r <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               active_r <= 1'b0;
               done_r   <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign bus.shot_x      = x_r;
   assign bus.shot_y      = y_r;
   assign bus.shot_active = active_r;
   assign bus.shot_done   = done_r;
   assign bus.shot_hit    = hit_r;

endmodule

// File: tb/tb_shot_traj.sv
// Directed bench for shot_traj with hand-computed expected positions.
module tb_shot_traj;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   shot_traj_if bus ();

   shot_traj #(.Y_MAX(15)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      bus.step_tick = 1'b1;
      cyc();
      bus.step_tick = 1'b0;
   endtask

   task automatic launch(input logic [4:0] x, input logic [4:0] r, input logic [4:0] ri, input logic d);
      bus.x_pos = x;
      bus.run   = r;
      bus.rise  = ri;
      bus.dir   = d;
      bus.fire  = 1'b1;
      cyc();
      bus.fire  = 1'b0;
   endtask

   task automatic end_by_hit();
      bus.hit = 1'b1;
      cyc();
      bus.hit = 1'b0;
      cyc();
   endtask

   logic [4:0] rw_x [7];

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rw_x = '{5'd30, 5'd28, 5'd26, 5'd24, 5'd22, 5'd20, 5'd18};
      bus.fire = 0; bus.step_tick = 0; bus.hit = 0;
      bus.x_pos = 0; bus.run = 0; bus.rise = 0; bus.dir = 0;
      reset = 1'b0;
      #2;
      cyc();
      cyc();
      check("rst_x", bus.shot_x, 0);
      check("rst_y", bus.shot_y, 0);
      check("rst_active", bus.shot_active, 0);
      check("rst_done", bus.shot_done, 0);
      check("rst_hit", bus.shot_hit, 0);
      reset = 1'b1;
      cyc();

      // Vertical shot to the top row
      launch(5'd10, 5'd0, 5'd1, 1'b0);
      check("vert_launch_active", bus.shot_active, 1);
      check("vert_launch_x", bus.shot_x, 10);
      check("vert_launch_y", bus.shot_y, 0);
      for (int i = 1; i <= 15; i++) begin
         tick();
         check("vert_y", bus.shot_y, i);
         check("vert_x", bus.shot_x, 10);
      end
      tick();
      check("vert_done", bus.shot_done, 1);
      check("vert_hit", bus.shot_hit, 0);
      check("vert_final_y", bus.shot_y, 15);
      check("vert_inactive", bus.shot_active, 0);
      // fire at M+1 ignored, M+2 launches
      bus.x_pos = 5'd5; bus.rise = 5'd1; bus.fire = 1'b1;
      cyc();
      check("m1_no_launch", bus.shot_active, 0);
      check("m1_done_clear", bus.shot_done, 0);
      cyc();
      bus.fire = 1'b0;
      check("m2_launch", bus.shot_active, 1);
      check("m2_x", bus.shot_x, 5);
      bus.hit = 1'b1;
      cyc();
      bus.hit = 1'b0;
      check("m2_hit_done", bus.shot_done, 1);
      check("m2_hit", bus.shot_hit, 1);
      check("m2_hit_y", bus.shot_y, 0);
      cyc();

      // Left wall reflection; aim changes and fire during flight are ignored
      launch(5'd1, 5'd2, 5'd1, 1'b0);
      bus.run = 5'd7; bus.dir = 1'b1; bus.x_pos = 5'd20; bus.fire = 1'b1;
      tick();
      check("lw_x1", bus.shot_x, 1);
      check("lw_y1", bus.shot_y, 1);
      tick();
      check("lw_x2", bus.shot_x, 3);
      check("lw_y2", bus.shot_y, 2);
      tick();
      check("lw_x3", bus.shot_x, 5);
      check("lw_y3", bus.shot_y, 3);
      bus.fire = 1'b0;
      end_by_hit();

      // Right wall reflection, flight ends one step short of overflow
      launch(5'd30, 5'd2, 5'd2, 1'b1);
      for (int i = 0; i < 7; i++) begin
         tick();
         check("rw_x", bus.shot_x, rw_x[i]);
         check("rw_y", bus.shot_y, 2 * (i + 1));
      end
      check("rw_still_active", bus.shot_active, 1);
      tick();
      check("rw_done", bus.shot_done, 1);
      check("rw_hit", bus.shot_hit, 0);
      check("rw_final_x", bus.shot_x, 18);
      check("rw_final_y", bus.shot_y, 14);
      cyc();
      check("rw_done_pulse", bus.shot_done, 0);

      // Hit takes priority over a simultaneous step
      launch(5'd12, 5'd0, 5'd1, 1'b1);
      tick(); tick(); tick();
      check("hp_pre_y", bus.shot_y, 3);
      bus.hit = 1'b1; bus.step_tick = 1'b1;
      cyc();
      bus.hit = 1'b0; bus.step_tick = 1'b0;
      check("hp_done", bus.shot_done, 1);
      check("hp_hit", bus.shot_hit, 1);
      check("hp_x", bus.shot_x, 12);
      check("hp_y", bus.shot_y, 3);
      cyc();
      check("hp_done_clear", bus.shot_done, 0);
      check("hp_hit_hold", bus.shot_hit, 1);

      // Fire with zero rise is not a launch
      launch(5'd7, 5'd3, 5'd0, 1'b1);
      check("rise0_no_launch", bus.shot_active, 0);
      cyc();
      check("rise0_idle", bus.shot_active, 0);

      // Reset mid-flight
      launch(5'd8, 5'd1, 5'd1, 1'b1);
      for (int i = 0; i < 5; i++) tick();
      check("mr_pre_y", bus.shot_y, 5);
      check("mr_pre_x", bus.shot_x, 13);
      reset = 1'b0;
      cyc();
      check("mr_x", bus.shot_x, 0);
      check("mr_y", bus.shot_y, 0);
      check("mr_active", bus.shot_active, 0);
      check("mr_done", bus.shot_done, 0);
      check("mr_hit", bus.shot_hit, 0);
      cyc();
      check("mr_done2", bus.shot_done, 0);
      reset = 1'b1;
      // Fire and step together in IDLE: launch only
      bus.step_tick = 1'b1;
      launch(5'd3, 5'd4, 5'd1, 1'b1);
      bus.step_tick = 1'b0;
      check("relaunch_active", bus.shot_active, 1);
      check("relaunch_x", bus.shot_x, 3);
      check("relaunch_y", bus.shot_y, 0);
      tick();
      check("relaunch_step_x", bus.shot_x, 7);
      check("relaunch_step_y", bus.shot_y, 1);
      end_by_hit();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/shot_traj.md
# shot_traj

Projectile trajectory engine sitting directly downstream of the aim/position stage. On a fire request it latches the shooter column and the current aim vector (run, rise, dir), then advances a shot across a 32-column playfield one step per movement tick. The shot reflects off the side walls and ends at the top row or on a hit reported by the collision logic. Outputs drive the renderer and the collision checker.

## Interface
- Y_MAX, default 15: highest row index; a step that would exceed it ends the flight.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-low; state clears on any edge with reset==0.
- fire  in  1  launch request; level-sampled, acted on only in IDLE.
- step_tick  in  1  one-cycle movement pacing pulse.
- hit  in  1  collision report for the current shot position.
- x_pos  in  5  shooter column, 0..31.
- run  in  5  horizontal step magnitude per tick.
- rise  in  5  vertical step per tick; 0 means invalid aim.
- dir  in  1  horizontal direction; 1 = increasing x, 0 = decreasing x.
- shot_x  out  5  current shot column.
- shot_y  out  5  current shot row, 0 = shooter row.
- shot_active  out  1  high while in FLY.
- shot_done  out  1  one-cycle pulse when a flight ends.
- shot_hit  out  1  valid with shot_done; 1 = ended by hit, 0 = reached top.

## Operation
- States: IDLE, FLY, DONE.
- IDLE: if fire==1 and rise!=0, latch run_l=run, rise_l=rise, dir_l=dir; load shot_x=x_pos, shot_y=0; go FLY. fire with rise==0 is ignored.
- FLY, priority order:
  - hit==1: go DONE with shot_hit=1; position unchanged, even if step_tick is also high.
  - step_tick==1 and shot_y+rise_l > Y_MAX: go DONE with shot_hit=0; position unchanged.
  - step_tick==1 otherwise: shot_y += rise_l, and shot_x moves per the horizontal rule below.
- Horizontal rule, 6-bit arithmetic:
  - dir_l=0: if run_l > shot_x, new x = run_l - shot_x and dir_l flips to 1; else x - run_l.
  - dir_l=1: if x + run_l > 31, new x = 62 - (x + run_l) and dir_l flips to 0; else x + run_l.
  - Result is always 0..31 for any run_l 0..31. run_l=0 means a vertical shot, with no reflection.
- DONE: shot_done=1 and shot_active=0 for exactly one cycle; shot_x/shot_y hold the final position; go IDLE. fire in DONE is ignored.
- Latched run/rise/dir are immune to x_pos, aim, or dir changes during flight. fire in FLY is ignored.
- shot_hit holds its value until the next launch.

## Timing
- Reset: state IDLE; shot_x=0, shot_y=0, shot_active=0, shot_done=0, shot_hit=0, latched vector 0. Reset mid-flight aborts with no shot_done pulse.
- All outputs are registered.
- Fire sampled at edge N: shot_active=1 with shot_x=x_pos(N), shot_y=0 after edge N.
- A step_tick at edge M updates the position after edge M.
- Termination at edge M: shot_done=1 after edge M, cleared after M+1. A fire at M+1 is ignored; earliest relaunch is fire sampled at M+2.
- fire and step_tick together in IDLE: launch only, no step.

## Test plan
- Vertical: x_pos=10, run=0, rise=1, dir=0, fire; 15 ticks -> shot_y 1..15, shot_x=10. 16th tick -> shot_done pulse, shot_hit=0, shot_y=15.
- Left wall: x_pos=1, run=2, rise=1, dir=0 -> tick1 x=1 with dir flipped; tick2 x=3; tick3 x=5.
- Right wall: x_pos=30, run=2, rise=2, dir=1 -> tick1 x=30, y=2; tick2 x=28, y=4. With Y_MAX=15, tick8 ends the flight at y=14.
- Hit priority: in FLY at x=12, y=3, assert hit and step_tick together -> next cycle shot_done=1, shot_hit=1, x=12, y=3 unchanged.
- Ignored requests: fire with rise=0 -> no launch. Fire while active -> no relaunch. Changing run/dir mid-flight -> path unchanged.
- Reset mid-flight: set reset=0 at y=5 -> after edge all outputs 0, no shot_done. Release reset and fire -> normal launch.
